// File: rtl/display_pkg.sv
// Shared display-adapter definitions: raster FSM state encoding and the
// default pixel/line counter widths, also used by glyph-ROM addressing.
package display_pkg;

  // Default counter widths (glyph column / glyph row).
  localparam int DEF_PX_W = 4;
  localparam int DEF_LN_W = 4;

  // Raster pass state; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } raster_state_e;

  // True while a pass is actively counting.
  function automatic logic st_busy(input raster_state_e s);
    return (s == ST_RUN);
  endfunction

  // True once a pass has completed and is waiting for Start/ClrPx.
  function automatic logic st_done(input raster_state_e s);
    return (s == ST_DONE);
  endfunction

endpackage

// File: rtl/raster_position_counter_if.sv
// Control/status bundle between the display sequencer and the raster
// position counter. Optional load port group exists only when
// RASTER_POS_LOAD_EN is defined.
interface raster_position_counter_if
  import display_pkg::*;
#(
  parameter int PX_W = DEF_PX_W,
  parameter int LN_W = DEF_LN_W
);

  logic            ClrPx;
  logic            Start;
  logic            IncPx;
  logic [PX_W-1:0] PxLimit;
  logic [LN_W-1:0] LnLimit;
  logic [PX_W-1:0] PxOut;
  logic [LN_W-1:0] LnOut;
  logic            PxWrap;
  logic            LnWrap;
  logic            Busy;
  logic            Done;
`ifdef RASTER_POS_LOAD_EN
  logic            LoadEn;
  logic [PX_W-1:0] LoadPx;
  logic [LN_W-1:0] LoadLn;

  // Sequencer side: drives commands, observes position and status.
  modport master (
    output ClrPx, Start, IncPx, PxLimit, LnLimit, LoadEn, LoadPx, LoadLn,
    input  PxOut, LnOut, PxWrap, LnWrap, Busy, Done
  );

  // Counter side.
  modport slave (
    input  ClrPx, Start, IncPx, PxLimit, LnLimit, LoadEn, LoadPx, LoadLn,
    output PxOut, LnOut, PxWrap, LnWrap, Busy, Done
  );
`else
  // Sequencer side: drives commands, observes position and status.
  modport master (
    output ClrPx, Start, IncPx, PxLimit, LnLimit,
    input  PxOut, LnOut, PxWrap, LnWrap, Busy, Done
  );

  // Counter side.
  modport slave (
    input  ClrPx, Start, IncPx, PxLimit, LnLimit,
    output PxOut, LnOut, PxWrap, LnWrap, Busy, Done
  );
`endif

endinterface

// File: rtl/raster_position_counter_wrap_counter.sv
// Single-axis modulo counter with inclusive programmable limit.
// Priority: clear > load > increment. A wrap pulse is registered together
// with the wrapped (zero) count so both become visible on the same cycle.
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         at_limit_o
);

  logic [W-1:0] count_q, count_d;
  logic         wrap_q,  wrap_d;

  // Loaded positions never exceed the active limit.
  function automatic logic [W-1:0] clamp(input logic [W-1:0] v,
                                         input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign at_limit_o = (count_q == limit_i);

  // Next count and wrap pulse; the pulse defaults low so it lasts one cycle.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = clamp(load_val_i, limit_i);
    end else if (inc_i) begin
      if (at_limit_o) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/raster_position_counter.sv
// Two-axis raster position counter (pixel within line, line within pass).
// A Start latches the limits into shadow registers and runs one pass; the
// final line wrap moves the FSM to DONE. Optional feature macro:
// RASTER_POS_LOAD_EN adds LoadEn/LoadPx/LoadLn to preset the position.
module raster_position_counter
  import display_pkg::*;
#(
  parameter int PX_W = DEF_PX_W,
  parameter int LN_W = DEF_LN_W
) (
  input  logic                      clock,
  input  logic                      ResetN,
  raster_position_counter_if.slave  bus
);

  raster_state_e   state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PX_W-1:0] px_lim_q, px_lim_d;
  logic [LN_W-1:0] ln_lim_q, ln_lim_d;

  logic            run;
  logic            clr_cnt;
  logic            load_req;
  logic            do_load;
  logic            px_inc;
  logic            ln_inc;
  logic            pass_end;
  logic            px_at_lim;
  logic            ln_at_lim;
  logic [PX_W-1:0] load_px;
  logic [LN_W-1:0] load_ln;
  logic [PX_W-1:0] px_cnt;
  logic [LN_W-1:0] ln_cnt;
  logic            px_wrap;
  logic            ln_wrap;

`ifdef RASTER_POS_LOAD_EN
  assign load_req = bus.LoadEn;
  assign load_px  = bus.LoadPx;
  assign load_ln  = bus.LoadLn;
`else
  assign load_req = 1'b0;
  assign load_px  = '0;
  assign load_ln  = '0;
`endif

  assign run     = st_busy(state_q);
  // Start also restarts the counters from zero.
  assign clr_cnt = bus.ClrPx | bus.Start;
  // A load only applies mid-pass and swallows that cycle's IncPx.
  assign do_load = run & load_req & ~clr_cnt;
  assign px_inc  = run & bus.IncPx & ~load_req & ~clr_cnt;
  // The line axis advances exactly when the pixel axis wraps.
  assign ln_inc  = px_inc & px_at_lim;
  assign pass_end = ln_inc & ln_at_lim;

  wrap_counter #(.W(PX_W)) u_px (
    .clk_i      (clock),
    .rst_n_i    (ResetN),
    .clr_i      (clr_cnt),
    .load_i     (do_load),
    .inc_i      (px_inc),
    .limit_i    (px_lim_q),
    .load_val_i (load_px),
    .count_o    (px_cnt),
    .wrap_o     (px_wrap),
    .at_limit_o (px_at_lim)
  );

  wrap_counter #(.W(LN_W)) u_ln (
    .clk_i      (clock),
    .rst_n_i    (ResetN),
    .clr_i      (clr_cnt),
    .load_i     (do_load),
    .inc_i      (ln_inc),
    .limit_i    (ln_lim_q),
    .load_val_i (load_ln),
    .count_o    (ln_cnt),
    .wrap_o     (ln_wrap),
    .at_limit_o (ln_at_lim)
  );

  // Next state, status flags and shadow limits; ClrPx overrides Start.
  always_comb begin
    state_d  = state_q;
    px_lim_d = px_lim_q;
    ln_lim_d = ln_lim_q;
    if (bus.ClrPx) begin
      state_d = ST_IDLE;
    end else if (bus.Start) begin
      state_d  = ST_RUN;
      px_lim_d = bus.PxLimit;
      ln_lim_d = bus.LnLimit;
    end else if (pass_end) begin
      state_d = ST_DONE;
    end
    busy_d = st_busy(state_d);
    done_d = st_done(state_d);
  end

  // State, registered status flags and limits latched at Start.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      px_lim_q <= '0;
      ln_lim_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      px_lim_q <= px_lim_d;
      ln_lim_q <= ln_lim_d;
    end
  end

  assign bus.PxOut  = px_cnt;
  assign bus.LnOut  = ln_cnt;
  assign bus.PxWrap = px_wrap;
  assign bus.LnWrap = ln_wrap;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule

// File: tb/tb_raster_position_counter.sv
// Scoreboard bench for raster_position_counter: the driver predicts each
// edge's outcome from a linear-position model and queues it; a monitor
// compares the DUT one step after each rising edge.
module tb_raster_position_counter;

  localparam int PX_W = 4;
  localparam int LN_W = 4;

  typedef struct {
    int px;
    int ln;
    int pw;
    int lw;
    int busy;
    int done;
  } exp_t;

  logic clock;
  logic ResetN;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Reference model: 0 idle, 1 running, 2 done.
  int m_st, m_px, m_ln, m_pl, m_ll, m_pw, m_lw;

  raster_position_counter_if #(.PX_W(PX_W), .LN_W(LN_W)) bus ();

  raster_position_counter #(.PX_W(PX_W), .LN_W(LN_W)) dut (
    .clock  (clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_px = 0; m_ln = 0; m_pl = 0; m_ll = 0; m_pw = 0; m_lw = 0;
  endtask

  // Position is treated as one linear index ln*(pl+1)+px across the pass.
  task automatic model_step(input int c, input int s, input int i,
                            input int pl, input int ll,
                            input int le, input int lpx, input int lln);
    int pos, per_line, total;
    m_pw = 0;
    m_lw = 0;
    if (c != 0) begin
      m_st = 0; m_px = 0; m_ln = 0;
    end else if (s != 0) begin
      m_st = 1; m_px = 0; m_ln = 0; m_pl = pl; m_ll = ll;
    end else if (m_st == 1 && le != 0) begin
      m_px = (lpx > m_pl) ? m_pl : lpx;
      m_ln = (lln > m_ll) ? m_ll : lln;
    end else if (m_st == 1 && i != 0) begin
      per_line = m_pl + 1;
      total    = (m_ll + 1) * per_line;
      pos      = m_ln * per_line + m_px + 1;
      if (pos == total) begin
        m_px = 0; m_ln = 0; m_pw = 1; m_lw = 1; m_st = 2;
      end else begin
        m_px = pos % per_line;
        m_ln = pos / per_line;
        m_pw = (m_px == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.px = m_px; e.ln = m_ln; e.pw = m_pw; e.lw = m_lw;
    e.busy = (m_st == 1) ? 1 : 0;
    e.done = (m_st == 2) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, predict, then advance to rising edge + 2.
  task automatic step_full(input int c, input int s, input int i,
                           input int pl, input int ll,
                           input int le, input int lpx, input int lln);
    bus.ClrPx   = c[0];
    bus.Start   = s[0];
    bus.IncPx   = i[0];
    bus.PxLimit = pl[PX_W-1:0];
    bus.LnLimit = ll[LN_W-1:0];
`ifdef RASTER_POS_LOAD_EN
    bus.LoadEn  = le[0];
    bus.LoadPx  = lpx[PX_W-1:0];
    bus.LoadLn  = lln[LN_W-1:0];
    model_step(c, s, i, pl, ll, le, lpx, lln);
`else
    model_step(c, s, i, pl, ll, 0, lpx, lln);
`endif
    push_exp();
    @(posedge clock);
    #2;
  endtask

  task automatic step(input int c, input int s, input int i, input int pl, input int ll);
    step_full(c, s, i, pl, ll, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".PxOut"},  32'(bus.PxOut),  0);
    chk({tag, ".LnOut"},  32'(bus.LnOut),  0);
    chk({tag, ".PxWrap"}, 32'(bus.PxWrap), 0);
    chk({tag, ".LnWrap"}, 32'(bus.LnWrap), 0);
    chk({tag, ".Busy"},   32'(bus.Busy),   0);
    chk({tag, ".Done"},   32'(bus.Done),   0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    bus.ClrPx = 1'b0; bus.Start = 1'b0; bus.IncPx = 1'b0;
`ifdef RASTER_POS_LOAD_EN
    bus.LoadEn = 1'b0;
`endif
    ResetN = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    #2;
    ResetN = 1'b1;
    @(posedge clock);
    #2;
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("PxOut",  32'(bus.PxOut),  e.px);
        chk("LnOut",  32'(bus.LnOut),  e.ln);
        chk("PxWrap", 32'(bus.PxWrap), e.pw);
        chk("LnWrap", 32'(bus.LnWrap), e.lw);
        chk("Busy",   32'(bus.Busy),   e.busy);
        chk("Done",   32'(bus.Done),   e.done);
      end
    end
  end

  // Stimulus.
  initial begin
    int c, s, i, pl, ll, le, lpx, lln;
    ResetN = 1'b0;
    bus.ClrPx = 1'b0; bus.Start = 1'b0; bus.IncPx = 1'b0;
    bus.PxLimit = '0; bus.LnLimit = '0;
`ifdef RASTER_POS_LOAD_EN
    bus.LoadEn = 1'b0; bus.LoadPx = '0; bus.LoadLn = '0;
`endif
    model_reset();
    #1;
    check_zero("por");
    @(posedge clock);
    #2;
    ResetN = 1'b1;
    @(posedge clock);
    #2;

    // Reset mid-pass with PxOut=5.
    step(0, 1, 0, 9, 3);
    repeat (5) step(0, 0, 1, 9, 3);
    chk("pre_reset.PxOut", 32'(bus.PxOut), 5);
    do_reset("async_rst");

    // 4x2 pass, then one extra IncPx in DONE.
    step(0, 1, 0, 3, 1);
    repeat (9) step(0, 0, 1, 3, 1);

    // Zero pixel limit: PxWrap on every advance.
    step(0, 1, 0, 0, 2);
    repeat (4) step(0, 0, 1, 0, 2);

    // Limits changed mid-pass are ignored.
    step(0, 1, 0, 7, 0);
    repeat (9) step(0, 0, 1, 2, 5);

    // ClrPx beats IncPx at the wrap point.
    step(0, 1, 0, 2, 3);
    repeat (2) step(0, 0, 1, 2, 3);
    step(1, 0, 1, 2, 3);
    step(0, 0, 1, 2, 3);

    // All-ones limits roll over naturally; Start mid-pass restarts.
    step(0, 1, 0, 15, 15);
    repeat (20) step(0, 0, 1, 15, 15);
    step(0, 1, 1, 1, 0);
    repeat (3) step(0, 0, 1, 1, 0);

`ifdef RASTER_POS_LOAD_EN
    // Load clamps to the shadow limit and suppresses the increment.
    step(0, 1, 0, 9, 3);
    step_full(0, 0, 1, 9, 3, 1, 12, 2);
    step(0, 0, 1, 9, 3);
`endif

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_rst");
      end else begin
        c   = ($urandom_range(0, 59) == 0) ? 1 : 0;
        s   = ($urandom_range(0, 39) == 0) ? 1 : 0;
        i   = ($urandom_range(0, 9) < 7) ? 1 : 0;
        pl  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
        ll  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
        le  = ($urandom_range(0, 9) == 0) ? 1 : 0;
        lpx = int'($urandom_range(0, 15));
        lln = int'($urandom_range(0, 15));
        step_full(c, s, i, pl, ll, le, lpx, lln);
      end
    end

    // Let the monitor drain, bounded.
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clock);
    #3;
    chk("drain", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
